// File: rtl/commit_trace_buffer.sv
// Purpose: capture retired-instruction records and serialise each as six 32-bit trace beats.
// Latency: a record pushed at edge N presents its header after edge N+1 at the earliest.
// Backpressure: beats hold while trace_ready is low; buf_full stalls the core, and records are dropped only if it is ignored.
module commit_trace_buffer #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hC7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_inst,
  input  logic        commit_halt,
  input  logic        commit_reg_we,
  input  logic [4:0]  commit_reg_wa,
  input  logic [31:0] commit_reg_wd,
  input  logic        commit_dmem_we,
  input  logic [31:0] commit_dmem_wa,
  input  logic [31:0] commit_dmem_wd,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_data,
  output logic        trace_last,
  output logic        buf_full,
  output logic        halted,
  output logic        drained,
  output logic [31:0] seq_cnt,
  output logic [15:0] drop_cnt
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_ONE   = (AW+1)'(1);
  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_SEND  = 1'b1;

  typedef struct packed {
    logic [15:0] seq;
    logic        halt;
    logic        reg_we;
    logic        dmem_we;
    logic [4:0]  reg_wa;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] reg_wd;
    logic [31:0] dmem_wa;
    logic [31:0] dmem_wd;
  } rec_t;

  rec_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [0:0]    r_state;
  logic [2:0]    r_beat;
  logic [31:0]   r_data;
  logic          r_last;
  logic          r_buf_full;
  logic          r_halted;
  logic          r_drained;
  logic [31:0]   r_seq;
  logic [15:0]   r_drop;

  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  rec_t          w_rec_in;
  logic [AW-1:0] w_rd_next;
  logic [AW:0]   w_count_nxt;
  logic          w_halted_nxt;
  logic [0:0]    w_state_nxt;
  logic [2:0]    w_beat_nxt;
  logic [31:0]   w_data_nxt;
  logic          w_last_nxt;

  // Beat payload for a stored record; data words go out regardless of their write-enable flags.
  function automatic logic [31:0] f_beat(input rec_t rec, input logic [2:0] idx);
    case (idx)
      3'd0:    f_beat = {SYNC_BYTE, rec.halt, rec.reg_we, rec.dmem_we, rec.reg_wa, rec.seq};
      3'd1:    f_beat = rec.pc;
      3'd2:    f_beat = rec.inst;
      3'd3:    f_beat = rec.reg_wd;
      3'd4:    f_beat = rec.dmem_wa;
      default: f_beat = rec.dmem_wd;
    endcase
  endfunction

  // Push/drop decisions use the registered count only, so a same-cycle pop never frees a slot.
  assign w_push    = commit && !r_halted && (r_count != L_DEPTH);
  assign w_drop    = commit && !r_halted && (r_count == L_DEPTH);
  assign w_pop     = (r_state == S_SEND) && trace_ready && (r_beat == 3'd5);
  assign w_rd_next = r_rd_ptr + 1'b1;

  assign w_rec_in = '{
    seq:     r_seq[15:0],
    halt:    commit_halt,
    reg_we:  commit_reg_we,
    dmem_we: commit_dmem_we,
    reg_wa:  commit_reg_wa,
    pc:      commit_pc,
    inst:    commit_inst,
    reg_wd:  commit_reg_wd,
    dmem_wa: commit_dmem_wa,
    dmem_wd: commit_dmem_wd
  };

  // Next occupancy and halt state, used for the registered status flags.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + L_ONE;
      2'b01:   w_count_nxt = r_count - L_ONE;
      default: w_count_nxt = r_count;
    endcase
    w_halted_nxt = r_halted | (w_push & commit_halt);
  end

  // Serialiser: output beat registers advance only on an accepted beat; the next record's
  // header is loaded straight after beat 5 when one is already queued, giving no bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = S_SEND;
          w_beat_nxt  = 3'd0;
          w_data_nxt  = f_beat(r_mem[r_rd_ptr], 3'd0);
          w_last_nxt  = 1'b0;
        end
      end
      S_SEND: begin
        if (trace_ready) begin
          if (r_beat == 3'd5) begin
            w_beat_nxt = 3'd0;
            w_last_nxt = 1'b0;
            if (r_count > L_ONE) begin
              w_data_nxt = f_beat(r_mem[w_rd_next], 3'd0);
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_beat_nxt = r_beat + 3'd1;
            w_data_nxt = f_beat(r_mem[r_rd_ptr], r_beat + 3'd1);
            w_last_nxt = (r_beat == 3'd4);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Record storage; the slot under the read pointer is never overwritten while occupied.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= w_rec_in;
    end
  end

  // Control state, counters and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_state    <= S_IDLE;
      r_beat     <= 3'd0;
      r_data     <= 32'd0;
      r_last     <= 1'b0;
      r_buf_full <= 1'b0;
      r_halted   <= 1'b0;
      r_drained  <= 1'b0;
      r_seq      <= 32'd0;
      r_drop     <= 16'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_seq    <= r_seq + 32'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      if (w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
      r_count    <= w_count_nxt;
      r_state    <= w_state_nxt;
      r_beat     <= w_beat_nxt;
      r_data     <= w_data_nxt;
      r_last     <= w_last_nxt;
      r_halted   <= w_halted_nxt;
      r_buf_full <= (w_count_nxt == L_DEPTH);
      r_drained  <= w_halted_nxt && (w_count_nxt == '0) && (w_state_nxt == S_IDLE);
    end
  end

  assign trace_valid = (r_state == S_SEND);
  assign trace_data  = r_data;
  assign trace_last  = r_last;
  assign buf_full    = r_buf_full;
  assign halted      = r_halted;
  assign drained     = r_drained;
  assign seq_cnt     = r_seq;
  assign drop_cnt    = r_drop;

endmodule
